timer_dev: RTL and testbench
============================

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter PRESCALE, default 0, meaning the count decrements once every PRESCALE+1 clock cycles (range 0..255).
REQ-002 SHALL have port Clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Addr  input  2  register select, 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port We  input  1  write enable for the register selected by Addr.
REQ-006 SHALL have port Din  input  32  write data.
REQ-007 SHALL have port Dout  output  32  read data for Addr, combinational.
REQ-008 SHALL have port IRQ  output  1  interrupt request, wired to one HWInt bit of the CP0.

Function
REQ-009 CTRL SHALL be 4 bits: bit0 Enable, bits2:1 Mode, bit3 IM; a read SHALL return {28'b0, CTRL}.
REQ-010 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be 32-bit read-only; writes to COUNT and Addr 3 SHALL be ignored; a read of Addr 3 SHALL return 0.
REQ-011 A PRESET write SHALL take effect only at the next LOAD state, never on a count in progress.
REQ-012 The FSM SHALL have states IDLE, LOAD, CNT and INT.
REQ-013 IDLE: Enable=1 -> LOAD at the next edge; otherwise remain; COUNT holds.
REQ-014 LOAD: COUNT <= PRESET and the prescaler is cleared; -> CNT at the next edge.
REQ-015 CNT: Enable=0 -> IDLE at the next edge with COUNT held; COUNT==0 -> INT at the next edge; on a tick with COUNT==1, COUNT <= 0 and -> INT; on a tick with COUNT>1, COUNT <= COUNT-1.
REQ-016 A tick SHALL occur in CNT when the prescaler equals PRESCALE; the prescaler SHALL then wrap to 0, otherwise increment.
REQ-017 IRQ SHALL equal (state==INT) AND IM, with no other gating.
REQ-018 In INT with Mode=0 (one-shot), hardware SHALL clear Enable at the next edge and remain in INT until any CTRL or PRESET write, then -> IDLE; IRQ remains a level until then.
REQ-019 In INT with Mode=1 (auto-reload), the FSM SHALL remain exactly one cycle, then -> LOAD; IRQ is a one-cycle pulse and the period is PRESET+2 cycles (PRESET>=1, PRESCALE=0).
REQ-020 Mode 2 and Mode 3 SHALL behave as Mode 0.
REQ-021 A software CTRL write in the same cycle as the hardware Enable clear SHALL win.
REQ-022 A CTRL write with Enable=0 in any state other than INT/Mode 0 SHALL force IDLE at the following edge.
REQ-023 COUNT SHALL never wrap below 0.
REQ-024 With PRESCALE=0 and PRESET>=1, IRQ SHALL rise after the (PRESET+2)th edge following the edge that latched the enabling CTRL write; with PRESET=0 it SHALL rise after the 3rd edge.

Reset
REQ-025 Reset low SHALL immediately set state=IDLE, CTRL=0, PRESET=0, COUNT=0, prescaler=0 and IRQ=0, independent of Clk.
REQ-026 Reset asserted mid-count or in INT SHALL drop IRQ asynchronously; after release, the block SHALL stay in IDLE until Enable is written.

Verification
REQ-027 PRESET=5, CTRL=0b1001 (IM, mode 0, enable): COUNT reads 5,4,3,2,1,0 on successive cycles; IRQ rises 7 edges after the CTRL write edge and stays high; CTRL reads 0b1000.
REQ-028 Continuing REQ-027, write CTRL=0: IRQ falls after the next edge and the state is IDLE; IRQ stays 0 afterwards.
REQ-029 PRESET=3, CTRL=0b1011 (mode 1): IRQ is a 1-cycle pulse every 5 cycles for 4 periods; writing PRESET=6 mid-count leaves the current period unchanged and makes the next period 8.
REQ-030 PRESCALE=3, PRESET=2, mode 0: COUNT decrements every 4 cycles; IRQ rises 10 edges after the CTRL write edge.
REQ-031 IM=0, mode 0, PRESET=1: the state reaches INT, COUNT=0 and Enable clears, but IRQ stays 0 throughout.
REQ-032 Reset pulsed low while COUNT=2 with IRQ previously high: outputs and registers are 0 immediately; no IRQ occurs until a re-enable.

Source files
------------

// File: rtl/timer_dev.sv
// timer_dev: programmable down-counting timer with CTRL/PRESET/COUNT registers.
// COUNT is loaded from PRESET in LOAD, decremented once per prescaler tick in
// CNT, and the FSM parks in INT (one-shot) or bounces back to LOAD
// (auto-reload) when it reaches zero. IRQ is the INT state masked by IM.
module timer_dev #(
  parameter int unsigned PRESCALE = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [7:0] PSC_MAX = PRESCALE[7:0];

  state_t      state;
  state_t      next_state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [7:0]  prescaler;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        enable;
  logic        im;
  logic        auto_reload;
  logic        tick;

  assign ctrl_wr     = We && (Addr == 2'd0);
  assign preset_wr   = We && (Addr == 2'd1);
  assign enable      = ctrl[0];
  assign im          = ctrl[3];
  assign auto_reload = (ctrl[2:1] == 2'd1);
  assign tick        = (state == CNT) && enable && (prescaler == PSC_MAX);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; Enable=0 pulls every active state except a one-shot INT
  // back to IDLE, since the one-shot INT clears Enable itself.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (enable) next_state = LOAD;
      end
      LOAD: begin
        next_state = enable ? CNT : IDLE;
      end
      CNT: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (count == '0) begin
          next_state = INT;
        end else if (tick && (count == 32'd1)) begin
          next_state = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          next_state = enable ? LOAD : IDLE;
        end else if (ctrl_wr || preset_wr) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Register file and counting datapath; a software CTRL write takes priority
  // over the hardware Enable clear in a one-shot INT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl      <= '0;
      preset    <= '0;
      count     <= '0;
      prescaler <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= Din[3:0];
      end else if ((state == INT) && !auto_reload) begin
        ctrl[0] <= 1'b0;
      end

      if (preset_wr) begin
        preset <= Din;
      end

      case (state)
        LOAD: begin
          count     <= preset;
          prescaler <= '0;
        end
        CNT: begin
          if (enable && (count != '0)) begin
            if (tick) begin
              count     <= count - 32'd1;
              prescaler <= '0;
            end else begin
              prescaler <= prescaler + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    Dout = '0;
    unique case (Addr)
      2'd0:    Dout = {28'b0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = '0;
    endcase
  end

  assign IRQ = (state == INT) && im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev: register access, one-shot, auto-reload,
// prescaler, IM masking, CTRL write priority and asynchronous reset.
module tb_timer_dev;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] dout;
  logic [31:0] dout3;
  logic        irq;
  logic        irq3;
  logic [31:0] rdata;
  logic [31:0] rdata3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  timer_dev #(.PRESCALE(0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Addr  (Addr),
    .We    (We),
    .Din   (Din),
    .Dout  (dout),
    .IRQ   (irq)
  );

  timer_dev #(.PRESCALE(3)) dut_p3 (
    .Clk   (Clk),
    .Reset (Reset),
    .Addr  (Addr),
    .We    (We),
    .Din   (Din),
    .Dout  (dout3),
    .IRQ   (irq3)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    We   = 1'b1;
    step();
    We   = 1'b0;
    Din  = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    Addr   = a;
    #1;
    rdata  = dout;
    rdata3 = dout3;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
  endtask

  initial begin
    Reset = 1'b0;
    We    = 1'b0;
    Addr  = 2'd0;
    Din   = '0;

    // Reset state
    #1;
    rd(2'd0); check("rst_ctrl", rdata, 32'h0);
    rd(2'd1); check("rst_preset", rdata, 32'h0);
    rd(2'd2); check("rst_count", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    step();
    step();
    Reset = 1'b1;
    step();

    // Register access
    wr(2'd1, 32'hA5A5_A5A5); rd(2'd1); check("preset_rw", rdata, 32'hA5A5_A5A5);
    wr(2'd0, 32'hFFFF_FFF6); rd(2'd0); check("ctrl_rw", rdata, 32'h0000_0006);
    wr(2'd2, 32'h0000_1234); rd(2'd2); check("count_ro", rdata, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF); rd(2'd3); check("rsvd_rd", rdata, 32'h0);
    wr(2'd0, 32'h0);

    // One-shot, PRESET=5, IM set
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 7; e++) begin
      step();
      check("os_irq", {31'b0, irq}, 32'(e == 7));
      if (e >= 2) begin
        rd(2'd2);
        check("os_count", rdata, 32'(7 - e));
      end
    end
    step();
    rd(2'd0); check("os_en_clr", rdata, 32'h8);
    check("os_irq_hold", {31'b0, irq}, 32'h1);
    step();
    step();
    check("os_irq_level", {31'b0, irq}, 32'h1);
    rd(2'd2); check("os_count_zero", rdata, 32'h0);

    // Leaving one-shot INT with CTRL=0
    wr(2'd0, 32'h0);
    check("os_irq_fall", {31'b0, irq}, 32'h0);
    for (int e = 0; e < 3; e++) begin
      step();
      check("idle_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd2); check("idle_count_hold", rdata, 32'h0);

    // Auto-reload, PRESET=3 then PRESET=6 written mid-count
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 33; e++) begin
      if (e == 23) wr(2'd1, 32'd6);
      else step();
      check("ar_irq", {31'b0, irq},
            32'((e == 5) || (e == 10) || (e == 15) || (e == 20) || (e == 25) || (e == 33)));
    end
    wr(2'd0, 32'h0);
    step();
    check("ar_stop_irq", {31'b0, irq}, 32'h0);

    // Software CTRL write coincident with the hardware Enable clear
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 3; e++) begin
      step();
      check("sw_irq", {31'b0, irq}, 32'(e == 3));
    end
    wr(2'd0, 32'h9);
    rd(2'd0); check("sw_wins", rdata, 32'h9);
    check("sw_irq_low", {31'b0, irq}, 32'h0);
    for (int e = 5; e <= 7; e++) begin
      step();
      check("sw_rerun_irq", {31'b0, irq}, 32'(e == 7));
    end

    // IM=0: INT reached silently
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 5; e++) begin
      step();
      check("im0_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd2); check("im0_count", rdata, 32'h0);
    rd(2'd0); check("im0_en_clr", rdata, 32'h0);

    // Asynchronous reset while IRQ is high
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step();
    step();
    step();
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    Reset = 1'b0;
    #1;
    check("async_irq_drop", {31'b0, irq}, 32'h0);
    rd(2'd0); check("async_ctrl", rdata, 32'h0);
    step();
    step();
    Reset = 1'b1;
    step();

    // Asynchronous reset with COUNT=2
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 4; e++) step();
    rd(2'd2); check("mid_count", rdata, 32'd2);
    Reset = 1'b0;
    #1;
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    rd(2'd2); check("mid_rst_count", rdata, 32'h0);
    rd(2'd1); check("mid_rst_preset", rdata, 32'h0);
    rd(2'd0); check("mid_rst_ctrl", rdata, 32'h0);
    step();
    step();
    Reset = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      check("post_rst_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd2); check("post_rst_count", rdata, 32'h0);
    // Re-enable with PRESET=0: IRQ after the third edge
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 3; e++) begin
      step();
      check("p0_irq", {31'b0, irq}, 32'(e == 3));
    end

    // PRESCALE=3 instance, PRESET=2
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int e = 1; e <= 10; e++) begin
      step();
      check("psc_irq", {31'b0, irq3}, 32'(e == 10));
      if (e >= 2) begin
        rd(2'd2);
        check("psc_count", rdata3, (e < 6) ? 32'd2 : ((e < 10) ? 32'd1 : 32'd0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
